pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised pipeline hazard and stall controller for the five-stage in-order core. It replaces fixed branch/busy stalling with a per-register countdown scoreboard that supports variable result latency. It detects RAW and WAW hazards at ID, inserts ID/EX bubbles, flushes on taken branches, freezes on a busy multi-cycle ALU, and counts stall cycles. It sits beside the pipeline registers and drives their enables.

## Interface
- NUM_REGS, 64: architectural registers tracked; register 0 is the zero register.
- REG_W, 6: register-id width; NUM_REGS <= 2**REG_W.
- MAX_LAT, 7: maximum issue-to-forwardable latency in cycles.
- LAT_W, $clog2(MAX_LAT+1): latency and counter width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ID_vld  in  1  valid instruction in ID.
- ID_rs1, ID_rs2  in  REG_W  source registers; 0 means unused.
- ID_rd  in  REG_W  destination register; 0 means none.
- ID_lat  in  LAT_W  cycles until the result is forwardable; 0 means no writeback.
- EX_take_br  in  1  taken branch resolved in EX.
- EX_alu_busy  in  1  multi-cycle ALU occupied.
- ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en  out  1  pipeline register enables.
- ST_id_ex_bubble  out  1  load an invalid NOP into ID/EX.
- ST_flush  out  1  load an invalid NOP into IF/ID and redirect IF.
- ST_issue  out  1  ID instruction accepted this cycle.
- ST_stall_cnt  out  32  cumulative stall cycles; wraps.

## Operation
- Scoreboard: one LAT_W countdown per register 1..NUM_REGS-1. Entry 0 is constant 0.
- Decide priority, highest first: rst, EX_alu_busy, EX_take_br, hazard, normal.
- rst:
  - All counters and ST_stall_cnt clear to 0.
  - All outputs are forced 0 while rst is high.
- EX_alu_busy:
  - if_id, id_ex and ex_mem enables are 0; mem_wb_en is 1, so MEM/WB drains a bubble.
  - Counters hold. ST_issue is 0. ST_stall_cnt increments.
  - A taken branch is deferred: EX holds EX_take_br until busy drops.
- EX_take_br:
  - ST_flush=1, ST_id_ex_bubble=1. All enables are 1.
  - ST_issue=0. The ID instruction is killed and its rd is not recorded.
  - ST_stall_cnt is unchanged.
- Hazard exists when ID_vld is high and any of these holds:
  - RAW: cnt[ID_rs1] != 0.
  - RAW: cnt[ID_rs2] != 0.
  - WAW: ID_lat != 0 and cnt[ID_rd] > ID_lat.
- On hazard:
  - ST_if_id_en=0, ST_id_ex_en=1, ST_id_ex_bubble=1. EX/MEM and MEM/WB enables are 1.
  - ST_issue=0. ST_stall_cnt increments.
- Normal: all enables 1, bubble 0, flush 0, ST_issue=ID_vld.
- Counter update each non-busy cycle, on the clock edge:
  - Every nonzero counter decrements by 1.
  - If ST_issue, ID_rd != 0 and ID_lat != 0, then cnt[ID_rd] loads ID_lat. The load overrides the decrement of the same entry.
- ID_lat values greater than MAX_LAT saturate to MAX_LAT.

## Timing
- All ST_* outputs except ST_stall_cnt are combinational from counters and current inputs.
- Counters and ST_stall_cnt update on the rising clk edge.
- RAW with latency L stalls the dependent instruction for exactly L cycles when it follows directly in ID. It issues in the cycle its counter reads 0.
- Independent back-to-back instructions issue every cycle with no bubbles.
- Reset asserted mid-stall clears all pending hazards immediately. The first cycle after release behaves as an empty scoreboard.

## Structure
- Shared package pipe_pkg holds:
  - REG_W, ZERO_REG and MAX_LAT.
  - The lat_t typedef (logic [LAT_W-1:0]).
  - The stall_ctrl_t struct bundling the four enables plus bubble, flush and issue.
- Sub-module sb_counter: one loadable, saturating-at-zero, freezeable countdown, instantiated in a generate loop per register.
- The hazard compare and priority mux are in the top level.

## Test plan
- Reset then ID_vld, rs1=5, rs2=6, rd=7, lat=1 -> ST_issue=1, no bubble, ST_stall_cnt=0; next cycle cnt[7]=1.
- Issue rd=5, lat=2; next instruction rs1=5 -> bubble on 2 consecutive cycles, issue on the 3rd; ST_stall_cnt=2.
- Issue rd=7, lat=3; next instruction rd=7, lat=1, no sources -> 2 stall cycles (cnt 3 then 2 exceed 1), issue when cnt=1.
- EX_take_br with ID_vld, rd=9, lat=2 -> ST_flush=1, ST_id_ex_bubble=1, ST_issue=0; cnt[9] stays 0; stall_cnt unchanged.
- cnt[3]=2, EX_alu_busy high 4 cycles -> cnt[3] holds 2; if_id/id_ex/ex_mem enables 0 and mem_wb_en 1 throughout; stall_cnt +4.
- rd=0, lat=4 issued, then rs1=0 -> no counter loaded, no stall; rst pulse while cnt[5]=3 -> cnt[5]=0 and a rs1=5 consumer issues immediately after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, latency type and stall-control bundle for the hazard controller
package pipe_pkg;
  localparam int NUM_REGS = 64;
  localparam int REG_W = 6;
  localparam int MAX_LAT = 7;
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  typedef logic [LAT_W-1:0] lat_t;
  typedef struct packed {
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic bubble;
    logic flush;
    logic issue;
  } stall_ctrl_t;
  localparam stall_ctrl_t ST_OFF = '0;
  localparam stall_ctrl_t ST_BUSY = 7'b0001_000;
  localparam stall_ctrl_t ST_FLUSH = 7'b1111_110;
  localparam stall_ctrl_t ST_HAZ = 7'b0111_100;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX status in, pipeline register controls out
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int LAT_W = pipe_pkg::LAT_W
);
  logic ID_vld;
  logic [REG_W-1:0] ID_rs1, ID_rs2, ID_rd;
  logic [LAT_W-1:0] ID_lat;
  logic EX_take_br, EX_alu_busy;
  logic ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en;
  logic ST_id_ex_bubble, ST_flush, ST_issue;
  logic [31:0] ST_stall_cnt;
  modport master (
    output ID_vld, ID_rs1, ID_rs2, ID_rd, ID_lat, EX_take_br, EX_alu_busy,
    input ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en, ST_id_ex_bubble, ST_flush, ST_issue, ST_stall_cnt
  );
  modport slave (
    input ID_vld, ID_rs1, ID_rs2, ID_rd, ID_lat, EX_take_br, EX_alu_busy,
    output ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en, ST_id_ex_bubble, ST_flush, ST_issue, ST_stall_cnt
  );
endinterface

// File: rtl/sb_counter.sv
// sb_counter: loadable countdown that stops at zero and freezes while frz is high
module sb_counter import pipe_pkg::*; #(
  parameter int W = LAT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic frz,
  input  logic ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (!frz) cnt <= ld ? ld_val : (cnt != '0 ? cnt - 1'b1 : cnt);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: countdown-scoreboard RAW/WAW detection, bubble/flush/freeze priority and stall counting
module pipe_hazard_ctrl #(
  parameter int NUM_REGS = pipe_pkg::NUM_REGS,
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int MAX_LAT = pipe_pkg::MAX_LAT,
  parameter int LAT_W = $clog2(MAX_LAT + 1)
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] lat_s;
  logic haz, ld_any;
  logic [31:0] stall_cnt;
  pipe_pkg::stall_ctrl_t st;
  assign cnt[0] = '0;
  assign lat_s = bus.ID_lat > LAT_W'(MAX_LAT) ? LAT_W'(MAX_LAT) : bus.ID_lat;
  // WAW only matters if the older write would land after the newer one
  assign haz = bus.ID_vld && (cnt[bus.ID_rs1] != '0 || cnt[bus.ID_rs2] != '0 ||
               (lat_s != '0 && cnt[bus.ID_rd] > lat_s));
  always_comb
    st = rst ? pipe_pkg::ST_OFF :
         bus.EX_alu_busy ? pipe_pkg::ST_BUSY :
         bus.EX_take_br ? pipe_pkg::ST_FLUSH :
         haz ? pipe_pkg::ST_HAZ : pipe_pkg::stall_ctrl_t'({6'b1111_00, bus.ID_vld});
  assign ld_any = st.issue && bus.ID_rd != pipe_pkg::ZERO_REG && lat_s != '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
    sb_counter #(.W(LAT_W)) u_cnt (
      .clk(clk), .rst(rst), .frz(bus.EX_alu_busy),
      .ld(ld_any && bus.ID_rd == REG_W'(g)), .ld_val(lat_s), .cnt(cnt[g])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (bus.EX_alu_busy || (!bus.EX_take_br && haz)) stall_cnt <= stall_cnt + 1;
  assign bus.ST_if_id_en = st.if_id_en;
  assign bus.ST_id_ex_en = st.id_ex_en;
  assign bus.ST_ex_mem_en = st.ex_mem_en;
  assign bus.ST_mem_wb_en = st.mem_wb_en;
  assign bus.ST_id_ex_bubble = st.bubble;
  assign bus.ST_flush = st.flush;
  assign bus.ST_issue = st.issue;
  assign bus.ST_stall_cnt = stall_cnt;
endmodule
